// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM state type and operand-signedness helpers.
package muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic a_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration on unsigned magnitudes: a shift-add multiply
// step or a restoring shift-subtract divide step, selected by div_mode_i.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic            div_mode_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] opnd_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic            ge;
    logic [XLEN-1:0] diff;

    // Multiply: {hi,lo} holds partial product in hi and the unconsumed
    // multiplier in lo. Divide: hi is the partial remainder, lo shifts the
    // dividend out and the quotient bits in.
    always_comb begin
        sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});
        shifted = {hi_i, lo_i[XLEN-1]};
        ge      = (shifted >= {1'b0, opnd_i});
        diff    = shifted[XLEN-1:0] - opnd_i;
        if (div_mode_i) begin
            hi_o = ge ? diff : shifted[XLEN-1:0];
            lo_o = {lo_i[XLEN-2:0], ge};
        end else begin
            hi_o = sum[XLEN:1];
            lo_o = {sum[0], lo_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: captures operands on start, runs
// 32 iterations (or a short special-case path) and returns a registered result.
//
// state | meaning
// IDLE  | waiting for start; busy=0
// CALC  | one iteration per cycle, counter 0..31; special cases leave after one idle cycle
// FIX   | sign correction / special-case select, result written, done pulsed
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    state_t          state_q, state_d;
    logic [4:0]      cnt_q;
    logic [2:0]      op_q;
    logic [XLEN-1:0] hi_q, lo_q, opnd_q;
    logic            sa_q, sb_q;
    logic            div0_q, ovf_q;
    logic            done_q;
    logic [XLEN-1:0] result_q;

    logic            sa_in, sb_in;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div0_in, ovf_in;
    logic            special;
    logic [XLEN-1:0] step_hi, step_lo;
    logic [XLEN-1:0] fix_val;

    // Operand conditioning at the start boundary.
    always_comb begin
        sa_in   = operand_a[XLEN-1] & a_is_signed(funct3);
        sb_in   = operand_b[XLEN-1] & b_is_signed(funct3);
        a_mag   = sa_in ? (~operand_a + 32'd1) : operand_a;
        b_mag   = sb_in ? (~operand_b + 32'd1) : operand_b;
        div0_in = funct3[2] && (operand_b == 32'd0);
        ovf_in  = funct3[2] && !funct3[0] && !div0_in
                  && (operand_a == 32'h8000_0000) && (operand_b == 32'hFFFF_FFFF);
    end

    assign special = div0_q | ovf_q;

    muldiv_step u_step (
        .div_mode_i (op_q[2]),
        .hi_i       (hi_q),
        .lo_i       (lo_q),
        .opnd_i     (opnd_q),
        .hi_o       (step_hi),
        .lo_o       (step_lo)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (special || (cnt_q == 5'd31)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: busy from state, final value selection for FIX
    always_comb begin
        logic [2*XLEN-1:0] prod;
        logic [2*XLEN-1:0] prod_fix;
        logic [XLEN-1:0]   quo_fix;
        logic [XLEN-1:0]   rem_fix;
        logic [XLEN-1:0]   a_orig;
        logic              neg;

        busy     = (state_q != IDLE);
        neg      = sa_q ^ sb_q;
        prod     = {hi_q, lo_q};
        prod_fix = neg ? (~prod + 64'd1) : prod;
        quo_fix  = neg ? (~lo_q + 32'd1) : lo_q;
        rem_fix  = sa_q ? (~hi_q + 32'd1) : hi_q;
        // lo_q still holds |dividend| on the special path since no step ran.
        a_orig   = sa_q ? (~lo_q + 32'd1) : lo_q;

        unique case (op_q)
            F3_MUL:                      fix_val = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_val = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:             fix_val = quo_fix;
            default:                     fix_val = rem_fix;
        endcase

        if (div0_q) begin
            fix_val = op_q[1] ? a_orig : 32'hFFFF_FFFF;
        end else if (ovf_q) begin
            fix_val = op_q[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= 5'd0;
            op_q     <= 3'd0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q   <= funct3;
                        sa_q   <= sa_in;
                        sb_q   <= sb_in;
                        div0_q <= div0_in;
                        ovf_q  <= ovf_in;
                        cnt_q  <= 5'd0;
                        hi_q   <= '0;
                        lo_q   <= funct3[2] ? a_mag : b_mag;
                        opnd_q <= funct3[2] ? b_mag : a_mag;
                    end
                end
                CALC: begin
                    if (!special) begin
                        hi_q  <= step_hi;
                        lo_q  <= step_lo;
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                FIX: begin
                    result_q <= fix_val;
                    done_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M vectors, randomized
// operations against an arithmetic reference model, handshake and reset cases.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] operand_a = 32'd0;
    logic [31:0] operand_b = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;

    muldiv_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .funct3    (funct3),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub, p;
        logic [63:0] pu;
        logic        ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ub  = {32'd0, b};
        pu  = {32'd0, a} * {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: return pu[31:0];
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: return pu[63:32];
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 0)) return 2;
        if (f3[2] && !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 33;
    endfunction

    // Drives one start pulse and waits (bounded) for done; lat counts edges after E.
    task automatic issue_and_wait(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output int lat);
        @(negedge clk);
        start = 1'b1; funct3 = f3; operand_a = a; operand_b = b;
        @(posedge clk); #1;
        start = 1'b0; funct3 = 3'($urandom); operand_a = $urandom; operand_b = $urandom;
        lat = 0;
        while (done !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
        tests++; if (result !== 32'd0) begin fails++; $display("FAIL reset_result got %h want 0", result); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed(input string name, input logic [2:0] f3[4], input logic [31:0] a[4],
                                 input logic [31:0] b[4], input logic [31:0] exp[4], input int exp_lat);
        logic [31:0] res;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            issue_and_wait(f3[i], a[i], b[i], res, lat);
            tests++;
            if (res !== exp[i]) begin
                fails++; $display("FAIL %s[%0d] result got %h want %h", name, i, res, exp[i]);
            end
            tests++;
            if (lat !== exp_lat) begin
                fails++; $display("FAIL %s[%0d] latency got %0d want %0d", name, i, lat, exp_lat);
            end
            tests++;
            if (busy !== 1'b0) begin
                fails++; $display("FAIL %s[%0d] busy_at_done got %b want 0", name, i, busy);
            end
            @(posedge clk); #1;
            tests++;
            if (done !== 1'b0 || result !== exp[i]) begin
                fails++; $display("FAIL %s[%0d] after_done done=%b result=%h want 0/%h", name, i, done, result, exp[i]);
            end
        end
    endtask

    task automatic test_mul();
        logic [2:0]  f3[4]  = '{3'd0, 3'd3, 3'd1, 3'd2};
        logic [31:0] a[4]   = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] b[4]   = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] exp[4] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h4000_0000, 32'hFFFF_FFFF};
        test_directed("mul", f3, a, b, exp, 33);
    endtask

    task automatic test_div();
        logic [2:0]  f3[4]  = '{3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] a[4]   = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] b[4]   = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] exp[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        test_directed("div", f3, a, b, exp, 33);
    endtask

    task automatic test_special();
        logic [2:0]  f3[4]  = '{3'd5, 3'd7, 3'd4, 3'd6};
        logic [31:0] a[4]   = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] b[4]   = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp[4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        logic [2:0]  f3s[4] = '{3'd4, 3'd6, 3'd6, 3'd4};
        logic [31:0] as[4]  = '{32'd5, 32'hFFFF_FFFB, 32'd9, 32'h8000_0000};
        logic [31:0] bs[4]  = '{32'd0, 32'd0, 32'd0, 32'd0};
        logic [31:0] es[4]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'd9, 32'hFFFF_FFFF};
        test_directed("special", f3, a, b, exp, 2);
        test_directed("signed_div0", f3s, as, bs, es, 2);
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a, b, res, exp;
        int          lat, exp_lat, sel;
        for (int i = 0; i < 80; i++) begin
            f3  = 3'($urandom);
            sel = $urandom_range(0, 7);
            a   = $urandom;
            b   = $urandom;
            case (sel)
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
                3: begin a = -$urandom_range(0, 300); b = $urandom_range(1, 20); end
                4: begin a = $urandom_range(0, 300); b = -$urandom_range(1, 20); end
                default: ;
            endcase
            exp     = model(f3, a, b);
            exp_lat = model_lat(f3, a, b);
            issue_and_wait(f3, a, b, res, lat);
            tests++;
            if (res !== exp || lat !== exp_lat) begin
                fails++;
                $display("FAIL random[%0d] f3=%0d a=%h b=%h got %h/lat %0d want %h/lat %0d",
                         i, f3, a, b, res, lat, exp, exp_lat);
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] exp;
        int          lat;
        logic        early;
        exp   = model(3'd0, 32'd1234, 32'd5678);
        early = 1'b0;
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; operand_a = 32'd1234; operand_b = 32'd5678;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL busy_after_start got %b want 1", busy); end
        repeat (9) begin
            @(posedge clk); #1;
            lat++;
            if (done === 1'b1) early = 1'b1;
        end
        start = 1'b1; funct3 = 3'd5; operand_a = 32'd99; operand_b = 32'd0;
        @(posedge clk); #1;
        lat++;
        start = 1'b0; operand_a = 32'hDEAD_BEEF; operand_b = 32'h1;
        while (done !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
            if (done === 1'b1 && lat < 33) early = 1'b1;
        end
        tests++; if (early !== 1'b0) begin fails++; $display("FAIL ignore_early_done got %b want 0", early); end
        tests++; if (lat !== 33) begin fails++; $display("FAIL ignore_latency got %0d want 33", lat); end
        tests++; if (result !== exp) begin fails++; $display("FAIL ignore_result got %h want %h", result, exp); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res, a2, b2, exp2;
        int          lat;
        issue_and_wait(3'd3, 32'hCAFE_0001, 32'h0001_F00D, res, lat);
        tests++;
        if (res !== model(3'd3, 32'hCAFE_0001, 32'h0001_F00D)) begin
            fails++; $display("FAIL b2b_first got %h want %h", res, model(3'd3, 32'hCAFE_0001, 32'h0001_F00D));
        end
        // done is high right now: start in this very cycle must be accepted
        a2 = $urandom; b2 = $urandom_range(1, 1000);
        exp2 = model(3'd6, a2, b2);
        start = 1'b1; funct3 = 3'd6; operand_a = a2; operand_b = b2;
        @(posedge clk); #1;
        start = 1'b0;
        tests++; if (busy !== 1'b1 || done !== 1'b0) begin
            fails++; $display("FAIL b2b_accept busy=%b done=%b want 1/0", busy, done);
        end
        lat = 0;
        while (done !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        tests++; if (lat !== 33) begin fails++; $display("FAIL b2b_latency got %0d want 33", lat); end
        tests++; if (result !== exp2) begin fails++; $display("FAIL b2b_result got %h want %h", result, exp2); end
        start = 1'b1; funct3 = 3'd7; operand_a = 32'd77; operand_b = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        tests++; if (lat !== 2 || result !== 32'd77) begin
            fails++; $display("FAIL b2b_fast got %h/lat %0d want 0000004d/lat 2", result, lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        int          lat;
        logic        saw;
        @(negedge clk);
        start = 1'b1; funct3 = 3'd1; operand_a = 32'h1234_5678; operand_b = 32'h8765_4321;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midreset_busy got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL midreset_done got %b want 0", done); end
        tests++; if (result !== 32'd0) begin fails++; $display("FAIL midreset_result got %h want 0", result); end
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) saw = 1'b1;
        end
        tests++; if (saw !== 1'b0) begin fails++; $display("FAIL midreset_stray_done got %b want 0", saw); end
        issue_and_wait(3'd1, 32'hFFFF_FF00, 32'h0000_0400, res, lat);
        tests++;
        if (res !== model(3'd1, 32'hFFFF_FF00, 32'h0000_0400) || lat !== 33) begin
            fails++; $display("FAIL midreset_recover got %h/lat %0d want %h/lat 33",
                              res, lat, model(3'd1, 32'hFFFF_FF00, 32'h0000_0400));
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
